// File: rtl/traffic_phase_scheduler.sv
// Phase scheduler for a two-street intersection with latched pedestrian walk.
// Street A is the rest phase; lamps, walk and state_o decode from the state register.
module traffic_phase_scheduler #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned T_MIN_GREEN = 5,
  parameter int unsigned T_MAX_GREEN = 20,
  parameter int unsigned T_YELLOW    = 3,
  parameter int unsigned T_ALLRED    = 1,
  parameter int unsigned T_WALK      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Sa,
  input  logic       Sb,
  input  logic       ped_req,
  output logic       Ga,
  output logic       Ya,
  output logic       Ra,
  output logic       Gb,
  output logic       Yb,
  output logic       Rb,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    A_GRN   = 3'd0,
    A_YEL   = 3'd1,
    ALL_RED = 3'd2,
    B_GRN   = 3'd3,
    B_YEL   = 3'd4,
    WALK    = 3'd5
  } phase_t;

  // Timer values on the exit edge of each phase (phase of length T ends at T-1).
  localparam logic [CNT_W-1:0] MIN_G_END = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_G_END = CNT_W'(T_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_END   = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_END    = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] WALK_END  = CNT_W'(T_WALK - 1);

  phase_t           state;
  phase_t           next;
  logic [CNT_W-1:0] timer;
  logic             last_b;
  logic             from_walk;

  always_comb begin
    next = state;
    case (state)
      A_GRN: begin
        if (timer >= MIN_G_END && (Sb || ped_pending) && (!Sa || timer >= MAX_G_END))
          next = A_YEL;
      end
      A_YEL: begin
        if (timer == YEL_END) next = ALL_RED;
      end
      ALL_RED: begin
        if (timer == AR_END) begin
          if (!from_walk && ped_pending) next = WALK;
          else if (last_b)               next = A_GRN;
          else if (Sb)                   next = B_GRN;
          else                           next = A_GRN;
        end
      end
      B_GRN: begin
        if (timer >= MIN_G_END && (!Sb || ((Sa || ped_pending) && timer >= MAX_G_END)))
          next = B_YEL;
      end
      B_YEL: begin
        if (timer == YEL_END) next = ALL_RED;
      end
      WALK: begin
        if (timer == WALK_END) next = ALL_RED;
      end
      default: next = A_GRN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= A_GRN;
      timer       <= '0;
      ped_pending <= 1'b0;
      last_b      <= 1'b0;
      from_walk   <= 1'b0;
    end else begin
      state <= next;
      if (next != state)   timer <= '0;
      else if (timer != '1) timer <= timer + CNT_W'(1);

      // Entering WALK serves the request; clear beats a same-edge set.
      if (next == WALK && state != WALK)  ped_pending <= 1'b0;
      else if (ped_req && state != WALK) ped_pending <= 1'b1;

      if (next != state) begin
        case (state)
          A_GRN: begin
            last_b    <= 1'b0;
            from_walk <= 1'b0;
          end
          B_GRN: begin
            last_b    <= 1'b1;
            from_walk <= 1'b0;
          end
          WALK:    from_walk <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    Ga   = 1'b0;
    Ya   = 1'b0;
    Ra   = 1'b0;
    Gb   = 1'b0;
    Yb   = 1'b0;
    Rb   = 1'b0;
    walk = 1'b0;
    case (state)
      A_GRN: begin
        Ga = 1'b1;
        Rb = 1'b1;
      end
      A_YEL: begin
        Ya = 1'b1;
        Rb = 1'b1;
      end
      B_GRN: begin
        Ra = 1'b1;
        Gb = 1'b1;
      end
      B_YEL: begin
        Ra = 1'b1;
        Yb = 1'b1;
      end
      WALK: begin
        Ra   = 1'b1;
        Rb   = 1'b1;
        walk = 1'b1;
      end
      default: begin
        Ra = 1'b1;
        Rb = 1'b1;
      end
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed per-cycle vector bench for traffic_phase_scheduler: each record is one
// clock edge's inputs plus the expected phase and pending flag after that edge.
module tb_traffic_phase_scheduler;

  localparam logic [2:0] S_AG = 3'd0;
  localparam logic [2:0] S_AY = 3'd1;
  localparam logic [2:0] S_AR = 3'd2;
  localparam logic [2:0] S_BG = 3'd3;
  localparam logic [2:0] S_BY = 3'd4;
  localparam logic [2:0] S_WK = 3'd5;

  typedef struct {
    logic       rst;
    logic       sa;
    logic       sb;
    logic       ped;
    logic [2:0] st;
    logic       pend;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Sa = 1'b0;
  logic       Sb = 1'b0;
  logic       ped_req = 1'b0;
  logic       Ga, Ya, Ra, Gb, Yb, Rb, walk, ped_pending;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vq[$];

  traffic_phase_scheduler #(
    .CNT_W(8), .T_MIN_GREEN(5), .T_MAX_GREEN(20),
    .T_YELLOW(3), .T_ALLRED(1), .T_WALK(6)
  ) dut (
    .clk(clk), .reset(reset), .Sa(Sa), .Sb(Sb), .ped_req(ped_req),
    .Ga(Ga), .Ya(Ya), .Ra(Ra), .Gb(Gb), .Yb(Yb), .Rb(Rb),
    .walk(walk), .ped_pending(ped_pending), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Lamp word {Ga,Ya,Ra,Gb,Yb,Rb,walk} required in each phase.
  function automatic logic [6:0] lamps_of(input logic [2:0] s);
    case (s)
      S_AG:    return 7'b1000010;
      S_AY:    return 7'b0100010;
      S_BG:    return 7'b0011000;
      S_BY:    return 7'b0010100;
      S_AR:    return 7'b0010010;
      S_WK:    return 7'b0010011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic void add(input logic rst, input logic sa, input logic sb,
                              input logic ped, input logic [2:0] st, input logic pend);
    vec_t v;
    v.rst = rst; v.sa = sa; v.sb = sb; v.ped = ped; v.st = st; v.pend = pend;
    vq.push_back(v);
  endfunction

  task automatic step(input logic r, input logic a, input logic b, input logic p);
    @(negedge clk);
    reset = r; Sa = a; Sb = b; ped_req = p;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [2:0] st, input logic pend);
    logic [6:0] lamps;
    lamps = {Ga, Ya, Ra, Gb, Yb, Rb, walk};
    n_tests++;
    if (state_o !== st) begin
      n_fail++;
      $display("FAIL %s[%0d] state_o: got %0d expected %0d", name, idx, state_o, st);
    end
    n_tests++;
    if (lamps !== lamps_of(st)) begin
      n_fail++;
      $display("FAIL %s[%0d] lamps: got %b expected %b", name, idx, lamps, lamps_of(st));
    end
    n_tests++;
    if (ped_pending !== pend) begin
      n_fail++;
      $display("FAIL %s[%0d] ped_pending: got %b expected %b", name, idx, ped_pending, pend);
    end
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].sa, vq[i].sb, vq[i].ped);
      check(name, i, vq[i].st, vq[i].pend);
    end
    vq.delete();
  endtask

  initial begin
    // Idle: stays in A green with no demand.
    add(1, 0, 0, 0, S_AG, 0);
    for (int i = 1; i <= 50; i++) add(0, 0, 0, 0, S_AG, 0);
    run_table("idle");

    // B demand only, then B demand drops after 10 cycles of B green.
    add(1, 0, 0, 0, S_AG, 0);
    for (int i = 1; i <= 4; i++)   add(0, 0, 1, 0, S_AG, 0);
    for (int i = 5; i <= 7; i++)   add(0, 0, 1, 0, S_AY, 0);
    add(0, 0, 1, 0, S_AR, 0);
    for (int i = 9; i <= 18; i++)  add(0, 0, 1, 0, S_BG, 0);
    for (int i = 19; i <= 21; i++) add(0, 0, 0, 0, S_BY, 0);
    add(0, 0, 0, 0, S_AR, 0);
    add(0, 0, 0, 0, S_AG, 0);
    add(0, 0, 0, 0, S_AG, 0);
    run_table("b_demand");

    // Both streets loaded: max-green alternation with period 48.
    for (int i = 0; i < 100; i++) begin
      int p;
      logic [2:0] s;
      p = i % 48;
      if (p < 20)       s = S_AG;
      else if (p < 23)  s = S_AY;
      else if (p == 23) s = S_AR;
      else if (p < 44)  s = S_BG;
      else if (p < 47)  s = S_BY;
      else              s = S_AR;
      add(i == 0, 1, 1, 0, s, 0);
    end
    run_table("both");

    // Pedestrian pulse alone; a second press during WALK is ignored.
    add(1, 0, 0, 0, S_AG, 0);
    add(0, 0, 0, 0, S_AG, 0);
    add(0, 0, 0, 1, S_AG, 1);
    add(0, 0, 0, 0, S_AG, 1);
    add(0, 0, 0, 0, S_AG, 1);
    for (int i = 5; i <= 7; i++)   add(0, 0, 0, 0, S_AY, 1);
    add(0, 0, 0, 0, S_AR, 1);
    for (int i = 9; i <= 14; i++)  add(0, 0, 0, (i == 11), S_WK, 0);
    add(0, 0, 0, 0, S_AR, 0);
    add(0, 0, 0, 0, S_AG, 0);
    add(0, 0, 0, 0, S_AG, 0);
    run_table("ped");

    // Pedestrian plus held B demand: walk first, then B green.
    add(1, 0, 0, 0, S_AG, 0);
    for (int i = 1; i <= 4; i++)   add(0, 0, 1, (i == 1), S_AG, 1);
    for (int i = 5; i <= 7; i++)   add(0, 0, 1, 0, S_AY, 1);
    add(0, 0, 1, 0, S_AR, 1);
    for (int i = 9; i <= 14; i++)  add(0, 0, 1, 0, S_WK, 0);
    add(0, 0, 1, 0, S_AR, 0);
    add(0, 0, 1, 0, S_BG, 0);
    add(0, 0, 1, 0, S_BG, 0);
    run_table("ped_b");

    // Long idle: timer must saturate, not wrap, so late demand exits at once.
    add(1, 0, 0, 0, S_AG, 0);
    for (int i = 1; i <= 257; i++) add(0, 0, 0, 0, S_AG, 0);
    add(0, 0, 1, 0, S_AY, 0);
    run_table("saturate");

    // Mid-operation reset during B green with a pending request.
    step(1, 0, 0, 0); check("mid_reset", 0, S_AG, 0);
    for (int i = 1; i <= 4; i++) begin step(0, 0, 1, 0); check("mid_reset", i, S_AG, 0); end
    for (int i = 5; i <= 7; i++) begin step(0, 0, 1, 0); check("mid_reset", i, S_AY, 0); end
    step(0, 0, 1, 0); check("mid_reset", 8, S_AR, 0);
    step(0, 0, 1, 0); check("mid_reset", 9, S_BG, 0);
    step(0, 0, 1, 1); check("mid_reset", 10, S_BG, 1);
    step(0, 0, 1, 0); check("mid_reset", 11, S_BG, 1);
    step(0, 0, 1, 0); check("mid_reset", 12, S_BG, 1);
    step(1, 0, 1, 0); check("mid_reset", 13, S_AG, 0);
    for (int i = 14; i <= 17; i++) begin step(0, 0, 1, 0); check("mid_reset", i, S_AG, 0); end
    step(0, 0, 1, 0); check("mid_reset", 18, S_AY, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
